// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and a one-entry valid/ready holding buffer
module uart_rx #(
  parameter  int CLKS_PER_BIT = 872,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s)
            state <= START;
        end
        START: begin
          if (timer == HALF_M1) begin
            timer   <= '0;
            bit_idx <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        DATA: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        STOP: begin
          if (timer == FULL_M1) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
              // A same-cycle accept frees the buffer for the new byte.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HI;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        WAIT_HI: begin
          timer <= '0;
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
